// File: rtl/sat_accum_mc.sv
// Multi-channel time-interleaved saturating accumulator with scaled, saturated output.
// Optional leaky integrator enabled by defining SAT_ACCUM_LEAK_EN.
module sat_accum_mc #(
   parameter int IWIDTH     = 16,
   parameter int AWIDTH     = 24,
   parameter int OWIDTH     = 16,
   parameter int NCHAN      = 4,
   parameter int CHW        = 2,
   parameter int SHIFT      = 8,
   parameter int LEAK_SHIFT = 12
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   input  logic                     in_first,
   input  logic signed [IWIDTH-1:0] din,
   input  logic                     clear,
   input  logic [NCHAN-1:0]         sat_ack,
   output logic                     out_valid,
   output logic [CHW-1:0]           out_chan,
   output logic signed [OWIDTH-1:0] dout,
   output logic [NCHAN-1:0]         sat_flags,
   output logic [15:0]              sat_count
);

   localparam int SW  = AWIDTH + 2;
   localparam int OSW = (AWIDTH > OWIDTH) ? AWIDTH : OWIDTH;

   localparam logic signed [SW-1:0]  AMAX = {3'b000, {(AWIDTH-1){1'b1}}};
   localparam logic signed [SW-1:0]  AMIN = {3'b111, {(AWIDTH-1){1'b0}}};
   localparam logic signed [OSW-1:0] OMAX = {{(OSW-OWIDTH+1){1'b0}}, {(OWIDTH-1){1'b1}}};
   localparam logic signed [OSW-1:0] OMIN = {{(OSW-OWIDTH+1){1'b1}}, {(OWIDTH-1){1'b0}}};

   // in_valid and out_valid are single-cycle strobes; there is no backpressure,
   // every accepted sample produces exactly one out_valid two cycles later.
   logic [CHW-1:0]           ch;
   logic [CHW-1:0]           cur;
   logic signed [AWIDTH-1:0] acc [NCHAN];
   logic signed [AWIDTH-1:0] acc_rd;
   logic signed [AWIDTH-1:0] acc_new;
   logic signed [SW-1:0]     acc_ext;
   logic signed [SW-1:0]     din_ext;
   logic signed [SW-1:0]     sum;
   logic                     sat_evt;
   logic [NCHAN-1:0]         set_vec;

   logic                     s1_valid;
   logic [CHW-1:0]           s1_chan;
   logic signed [AWIDTH-1:0] s1_acc;
   logic signed [OSW-1:0]    shifted;
   logic signed [OWIDTH-1:0] dout_sat;

   assign cur = in_first ? '0 : ch;

   always_comb begin
      acc_rd = '0;
      if (!clear) begin
         for (int i = 0; i < NCHAN; i++) begin
            if (cur == CHW'(i)) acc_rd = acc[i];
         end
      end
   end

   assign acc_ext = SW'(acc_rd);
   assign din_ext = SW'(din);

`ifdef SAT_ACCUM_LEAK_EN
   assign sum = acc_ext - (acc_ext >>> LEAK_SHIFT) + din_ext;
`else
   assign sum = acc_ext + din_ext;
`endif

   always_comb begin
      acc_new = sum[AWIDTH-1:0];
      sat_evt = 1'b0;
      if (sum > AMAX) begin
         acc_new = AMAX[AWIDTH-1:0];
         sat_evt = in_valid;
      end else if (sum < AMIN) begin
         acc_new = AMIN[AWIDTH-1:0];
         sat_evt = in_valid;
      end
   end

   always_comb begin
      set_vec = '0;
      for (int i = 0; i < NCHAN; i++) begin
         if (sat_evt && cur == CHW'(i)) set_vec[i] = 1'b1;
      end
   end

   assign shifted = OSW'(s1_acc >>> SHIFT);

   always_comb begin
      dout_sat = shifted[OWIDTH-1:0];
      if (shifted > OMAX)      dout_sat = OMAX[OWIDTH-1:0];
      else if (shifted < OMIN) dout_sat = OMIN[OWIDTH-1:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ch        <= '0;
         for (int i = 0; i < NCHAN; i++) acc[i] <= '0;
         s1_valid  <= 1'b0;
         s1_chan   <= '0;
         s1_acc    <= '0;
         out_valid <= 1'b0;
         out_chan  <= '0;
         dout      <= '0;
         sat_flags <= '0;
         sat_count <= '0;
      end else begin
         if (in_valid) ch <= (cur == CHW'(NCHAN-1)) ? '0 : cur + 1'b1;
         // the sampled channel takes the new value even when clear zeroes the rest
         for (int i = 0; i < NCHAN; i++) begin
            if (in_valid && cur == CHW'(i)) acc[i] <= acc_new;
            else if (clear)                 acc[i] <= '0;
         end
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_chan <= cur;
            s1_acc  <= acc_new;
         end
         out_valid <= s1_valid;
         if (s1_valid) begin
            out_chan <= s1_chan;
            dout     <= dout_sat;
         end
         sat_flags <= (sat_flags & ~sat_ack) | set_vec;
         if (sat_evt && sat_count != 16'hFFFF) sat_count <= sat_count + 16'd1;
      end
   end

endmodule
